// File: rtl/btn_pkg.sv
// Shared types and timing constants for the push-button step conditioner.
package btn_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } db_state_t;

  // Board timing at 100 MHz: 10 ms debounce, 0.5 s to first repeat, 0.1 s repeat period.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_EN       = 1;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;

  // Short timing used when simulating.
  localparam int unsigned SIM_DEBOUNCE = 4;
  localparam int unsigned SIM_DELAY    = 10;
  localparam int unsigned SIM_PERIOD   = 3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(64'(max_val) + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

  // Larger of two unsigned values.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_step_debounce_if.sv
// Button-side bundle: raw level in, conditioned level and pulses out.
interface btn_step_debounce_if;

  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic step_pulse;

  // Driver of the raw button and consumer of the conditioned outputs.
  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  step_pulse
  );

  // The conditioner itself.
  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output step_pulse
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_step_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release pulses and
// hold-to-repeat. step_pulse is the count enable for downstream counters.
module btn_step_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_step_debounce_if.slave   bus
);

  localparam int unsigned DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPT_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_ON      = (REPEAT_EN != 0);

  logic             btn_sync;
  db_state_t        state;
  db_state_t        state_c;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_cnt_c;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_c;
  logic [RPT_W-1:0] rpt_last_c;
  logic             rpt_periodic;
  logic             rpt_periodic_c;
  logic             press_c;
  logic             release_c;
  logic             repeat_c;
  logic             level_c;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (btn_sync)
  );

  // Next state, counters and next-cycle pulse values; pulses fire on the transition edge.
  always_comb begin
    state_c        = state;
    db_cnt_c       = db_cnt;
    rpt_cnt_c      = rpt_cnt;
    rpt_periodic_c = rpt_periodic;
    press_c        = 1'b0;
    release_c      = 1'b0;
    repeat_c       = 1'b0;
    rpt_last_c     = rpt_periodic ? PERIOD_LAST : DELAY_LAST;

    case (state)
      RELEASED: begin
        if (btn_sync) begin
          state_c  = CONFIRM_PRESS;
          db_cnt_c = '0;
        end
      end

      CONFIRM_PRESS: begin
        if (!btn_sync) begin
          state_c = RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_c        = PRESSED;
          press_c        = 1'b1;
          rpt_cnt_c      = '0;
          rpt_periodic_c = 1'b0;
        end else begin
          db_cnt_c = db_cnt + DB_W'(1);
        end
      end

      PRESSED: begin
        if (!btn_sync) begin
          // Leaving for confirmation freezes the repeat phase where it is.
          state_c  = CONFIRM_RELEASE;
          db_cnt_c = '0;
        end else if (RPT_ON) begin
          if (rpt_cnt == rpt_last_c) begin
            repeat_c       = 1'b1;
            rpt_cnt_c      = '0;
            rpt_periodic_c = 1'b1;
          end else begin
            rpt_cnt_c = rpt_cnt + RPT_W'(1);
          end
        end
      end

      CONFIRM_RELEASE: begin
        if (btn_sync) begin
          state_c = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_c   = RELEASED;
          release_c = 1'b1;
        end else begin
          db_cnt_c = db_cnt + DB_W'(1);
        end
      end

      default: begin
        state_c = RELEASED;
      end
    endcase

    level_c = (state_c == PRESSED) || (state_c == CONFIRM_RELEASE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= RELEASED;
      db_cnt            <= '0;
      rpt_cnt           <= '0;
      rpt_periodic      <= 1'b0;
      bus.btn_level     <= 1'b0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.step_pulse    <= 1'b0;
    end else begin
      state             <= state_c;
      db_cnt            <= db_cnt_c;
      rpt_cnt           <= rpt_cnt_c;
      rpt_periodic      <= rpt_periodic_c;
      bus.btn_level     <= level_c;
      bus.press_pulse   <= press_c;
      bus.release_pulse <= release_c;
      bus.repeat_pulse  <= repeat_c;
      bus.step_pulse    <= press_c | repeat_c;
    end
  end

endmodule

// File: tb/tb_btn_step_debounce.sv
// Directed bench for btn_step_debounce: expected pulse cycles are queued per
// scenario and retired as the DUT outputs are sampled each cycle.
module tb_btn_step_debounce;
  import btn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn = 1'b0;

  int checks = 0;
  int errors = 0;
  int e = 0;

  int press_q[$];
  int rel_q[$];
  int rpt_q[$];
  bit btn_pat[$];
  bit exp_level = 1'b0;
  int rst_from = -1;
  int rst_to = -1;

  always #5 clk = ~clk;

  btn_step_debounce_if bus_a ();
  btn_step_debounce_if bus_b ();

  assign bus_a.btn_in = btn;
  assign bus_b.btn_in = btn;

  btn_step_debounce #(
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (SIM_DELAY),
    .REPEAT_PERIOD   (SIM_PERIOD)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  btn_step_debounce #(
    .DEBOUNCE_CYCLES (SIM_DEBOUNCE),
    .REPEAT_EN       (0),
    .REPEAT_DELAY    (SIM_DELAY),
    .REPEAT_PERIOD   (SIM_PERIOD)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  function automatic bit pat(input int k);
    if (k < btn_pat.size()) return btn_pat[k];
    return btn_pat[btn_pat.size()-1];
  endfunction

  // Retire any expected events due this cycle, then compare both DUTs.
  task automatic check_cycle(input bit in_reset);
    bit ep;
    bit er;
    bit eq;
    ep = (press_q.size() > 0) && (press_q[0] == e);
    er = (rel_q.size() > 0) && (rel_q[0] == e);
    eq = (rpt_q.size() > 0) && (rpt_q[0] == e);
    if (ep) begin void'(press_q.pop_front()); exp_level = 1'b1; end
    if (er) begin void'(rel_q.pop_front()); exp_level = 1'b0; end
    if (eq) void'(rpt_q.pop_front());
    if (in_reset) exp_level = 1'b0;
    chk("a_press",   bus_a.press_pulse,   ep);
    chk("a_release", bus_a.release_pulse, er);
    chk("a_repeat",  bus_a.repeat_pulse,  eq);
    chk("a_step",    bus_a.step_pulse,    ep | eq);
    chk("a_level",   bus_a.btn_level,     exp_level);
    chk("b_press",   bus_b.press_pulse,   ep);
    chk("b_release", bus_b.release_pulse, er);
    chk("b_repeat",  bus_b.repeat_pulse,  1'b0);
    chk("b_step",    bus_b.step_pulse,    ep);
    chk("b_level",   bus_b.btn_level,     exp_level);
  endtask

  // Three reset cycles with the button toggling, then one idle cycle after release.
  task automatic do_reset();
    press_q.delete();
    rel_q.delete();
    rpt_q.delete();
    exp_level = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn = ~btn;
      @(posedge clk);
      e = -10 + i;
      #1;
      check_cycle(1'b1);
    end
    reset = 1'b0;
    btn = 1'b0;
    @(posedge clk);
    e = -1;
    #1;
    check_cycle(1'b0);
  endtask

  // Drive btn_pat edge by edge (element k is sampled at edge k) and check cycles 0..last.
  task automatic run_window(input int last);
    btn = pat(0);
    reset = (rst_from == 0);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      e = k;
      #1;
      check_cycle((k >= rst_from) && (k <= rst_to));
      btn = pat(k + 1);
      reset = ((k + 1) >= rst_from) && ((k + 1) <= rst_to);
    end
    reset = 1'b0;
    chk("press_q_drained",   logic'(press_q.size() == 0), 1'b1);
    chk("release_q_drained", logic'(rel_q.size() == 0),   1'b1);
    chk("repeat_q_drained",  logic'(rpt_q.size() == 0),   1'b1);
    rst_from = -1;
    rst_to = -1;
  endtask

  initial begin
    // Clean press, hold with auto-repeat, then steady release from edge 26.
    do_reset();
    btn_pat.delete();
    for (int i = 0; i < 26; i++) btn_pat.push_back(1'b1);
    btn_pat.push_back(1'b0);
    press_q.push_back(6);
    rpt_q.push_back(16); rpt_q.push_back(19); rpt_q.push_back(22); rpt_q.push_back(25);
    rel_q.push_back(32);
    run_window(40);

    // Bouncing press: 1,1,0,1,1,0 then steady 1 from edge 6, release from edge 14.
    do_reset();
    btn_pat.delete();
    btn_pat.push_back(1'b1); btn_pat.push_back(1'b1); btn_pat.push_back(1'b0);
    btn_pat.push_back(1'b1); btn_pat.push_back(1'b1); btn_pat.push_back(1'b0);
    for (int i = 6; i < 14; i++) btn_pat.push_back(1'b1);
    btn_pat.push_back(1'b0);
    press_q.push_back(12);
    rel_q.push_back(20);
    run_window(28);

    // Two-cycle low glitch at edges 17-18 while held: repeat cadence resumes, no release.
    do_reset();
    btn_pat.delete();
    for (int i = 0; i < 17; i++) btn_pat.push_back(1'b1);
    btn_pat.push_back(1'b0); btn_pat.push_back(1'b0);
    for (int i = 19; i < 28; i++) btn_pat.push_back(1'b1);
    btn_pat.push_back(1'b0);
    press_q.push_back(6);
    rpt_q.push_back(16); rpt_q.push_back(22); rpt_q.push_back(25); rpt_q.push_back(28);
    rel_q.push_back(34);
    run_window(40);

    // Reset at edges 18-19 while held: press re-detected once, in cycle 26.
    do_reset();
    btn_pat.delete();
    btn_pat.push_back(1'b1);
    rst_from = 18;
    rst_to = 19;
    press_q.push_back(6);
    rpt_q.push_back(16);
    press_q.push_back(26);
    run_window(30);

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_step_debounce.md
Name: btn_step_debounce

Overview:
- Upstream conditioning stage for the counter lab: takes a raw mechanical push-button and produces clean, single-cycle step pulses.
- Replaces driving counter clocks directly from a bouncing button. Counters run on the board clock and use step_pulse as their count enable.
- Provides a 2-flop synchronizer, a debounce FSM, press/release edge pulses and optional hold-to-auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized cycles required to accept a level change (10 ms at 100 MHz); must be >= 1.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 disables it, and repeat_pulse is then tied 0.
- REPEAT_DELAY, 50000000: cycles from press acceptance to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_in  in  1  raw asynchronous button level
- btn_level  out  1  debounced button level
- press_pulse  out  1  one-cycle pulse on an accepted press
- release_pulse  out  1  one-cycle pulse on an accepted release
- repeat_pulse  out  1  one-cycle auto-repeat pulse
- step_pulse  out  1  press_pulse OR repeat_pulse (count enable for downstream counters)

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port named reset. All state updates on the rising edge of clk only.
- Reset: sync flops 0, state RELEASED, all counters 0. All outputs 0 in the cycle after the reset edge.
- Synchronizer: btn_in -> s1 -> s2. The FSM uses s2 only.
- FSM states: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
  - RELEASED: s2=1 -> CONFIRM_PRESS, with db_cnt cleared to 0.
  - CONFIRM_PRESS: s2=0 -> RELEASED (bounce rejected, no pulse). If s2=1 and db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise db_cnt+1.
  - PRESSED: s2=0 -> CONFIRM_RELEASE, with db_cnt cleared.
  - CONFIRM_RELEASE: s2=1 -> PRESSED (glitch rejected, no pulses). If s2=0 and db_cnt==DEBOUNCE_CYCLES-1 -> RELEASED. Otherwise db_cnt+1.
- Latency: btn_in stable from before edge 0 gives the state change, and the registered pulse, in the cycle after edge DEBOUNCE_CYCLES+2.
- btn_level: 1 in PRESSED and CONFIRM_RELEASE, else 0.
- Pulses:
  - press_pulse is high exactly for the first cycle after entering PRESSED from CONFIRM_PRESS.
  - release_pulse is high exactly for the first cycle after entering RELEASED from CONFIRM_RELEASE.
  - A re-entry into PRESSED from CONFIRM_RELEASE produces no press_pulse.
- Auto-repeat:
  - rpt_cnt clears on entry to PRESSED from CONFIRM_PRESS, then counts each cycle in PRESSED.
  - First repeat_pulse occurs REPEAT_DELAY cycles after the press_pulse cycle. Subsequent pulses occur every REPEAT_PERIOD cycles.
  - rpt_cnt holds its value in CONFIRM_RELEASE, and no repeat pulses fire there. On a return to PRESSED, counting resumes without restart.
- Counter widths: $clog2(max+1) of the relevant parameter. Counters never wrap: db_cnt is consumed at its terminal value, and rpt_cnt reloads to the period phase.
- press_pulse and repeat_pulse are never high in the same cycle. step_pulse is high in at most one cycle per event.
- Reset mid-operation overrides everything, so pending pulses are dropped. If the button is held through reset, the press is re-detected normally after reset deasserts (one press_pulse, DEBOUNCE_CYCLES+2 latency).
- All outputs are registered: no combinational path from btn_in.

Decomposition:
- Package btn_pkg:
  - state enum typedef (RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE)
  - default timing constants
  - simulation-scale constants: DEBOUNCE=4, DELAY=10, PERIOD=3
- One sub-module, sync_2ff (1-bit 2-flop synchronizer with synchronous reset), reused for btnU when the reset button is conditioned.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Cycle numbers count clk edges from edge 0.)
- Reset: hold reset 3 cycles with btn_in toggling -> all outputs 0 throughout and in the first cycle after release.
- Clean press: btn_in=1 from before edge 0 -> press_pulse and step_pulse high only in cycle 6. btn_level=1 from cycle 6.
- Bounce: btn_in 1,1,0,1,1,0 then steady 1 from edge 6 -> no pulse before cycle 12. Exactly one press_pulse, in cycle 12.
- Hold with auto-repeat: press accepted in cycle 6 and held -> repeat_pulse in cycles 16, 19, 22, 25. step_pulse high in cycles 6, 16, 19, 22, 25. Repeat it with REPEAT_EN=0 -> step_pulse in cycle 6 only.
- Release and glitch:
  - A 2-cycle low glitch while held -> no release_pulse, and repeat cadence resumes with no restart.
  - Steady low from edge N -> release_pulse in cycle N+6, btn_level=0 from then on.
- Reset mid-hold: assert reset at cycle 18 while held, deassert at 20 with btn_in=1 -> outputs 0 in cycles 19-20, then a single press_pulse in cycle 26.
